vram_scheduler: RTL and testbench

- Controller that shares one dual-port block RAM (1 registered read port, 1 write port, 1-cycle read latency, read-first) among:
  - two read clients: client 0 = display scanner, client 1 = drawing/CPU logic;
  - one write client;
  - an internal clear sequencer that fills the whole memory with a constant.
- Sits between the etch-a-sketch pixel logic and the frame-buffer RAM instance, and drives all RAM address and enable pins.

---
 rtl/vram_sched_pkg.sv | 19 +
 rtl/vram_read_arbiter.sv | 50 +++++
 rtl/vram_scheduler.sv | 124 ++++++++++++
 tb/tb_vram_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vram_sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vram_sched_pkg : shared types for the frame-buffer RAM scheduler      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package vram_sched_pkg;

    localparam int unsigned NUM_RD_CLIENTS = 2;

    typedef logic [$clog2(NUM_RD_CLIENTS)-1:0] client_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/vram_read_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vram_read_arbiter : 2-way read arbiter, fixed priority or round-robin |
// | (VRAM_SCHED_RR_EN). Rev 1.0                                           |
// +-----------------------------------------------------------------------+
module vram_read_arbiter
    import vram_sched_pkg::*;
(
`ifdef VRAM_SCHED_RR_EN
    input  logic        clk,
    input  logic        rst_n,
`endif
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    output client_idx_t sel
);

`ifdef VRAM_SCHED_RR_EN
    client_idx_t ptr_q, ptr_d;

    always_comb begin
        gnt0  = req0 & (~req1 | (ptr_q == client_idx_t'(0)));
        gnt1  = req1 & (~req0 | (ptr_q == client_idx_t'(1)));
        ptr_d = ptr_q;
        // The pointer always hands priority to the client that was not just served.
        if (gnt0 | gnt1) begin
            ptr_d = client_idx_t'(gnt0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= client_idx_t'(0);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
    end
`endif

    assign sel = client_idx_t'(gnt1);

endmodule
`default_nettype wire

// File: rtl/vram_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vram_scheduler : shares one dual-port frame-buffer RAM among two read |
// | clients, a writer and a clear sequencer. Option: VRAM_SCHED_RR_EN.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module vram_scheduler
    import vram_sched_pkg::*;
#(
    parameter int           W           = 8,
    parameter int           L           = 32,
    parameter logic [W-1:0] CLEAR_VALUE = '0,
    localparam int          A           = $clog2(L)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd0_req,
    input  logic [A-1:0] rd0_addr,
    output logic         rd0_gnt,
    output logic         rd0_valid,
    input  logic         rd1_req,
    input  logic [A-1:0] rd1_addr,
    output logic         rd1_gnt,
    output logic         rd1_valid,
    output logic [W-1:0] rd_data,
    input  logic         wr_req,
    input  logic [A-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    output logic         wr_gnt,
    input  logic         clear_start,
    output logic         clear_busy,
    output logic         clear_done,
    output logic [A-1:0] ram_rd_addr,
    input  logic [W-1:0] ram_rd_data,
    output logic         ram_wr_ena,
    output logic [A-1:0] ram_wr_addr,
    output logic [W-1:0] ram_wr_data
);

    localparam logic [A-1:0] LAST_ROW = A'(L - 1);

    logic         gnt0;
    logic         gnt1;
    client_idx_t  rd_sel;
    clr_state_t   state_q, state_d;
    logic [A-1:0] cnt_q, cnt_d;
    logic         rd0_valid_q, rd1_valid_q;

    vram_read_arbiter u_arb (
`ifdef VRAM_SCHED_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .req0  (rd0_req),
        .req1  (rd1_req),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .sel   (rd_sel)
    );

    assign rd0_gnt     = gnt0;
    assign rd1_gnt     = gnt1;
    assign ram_rd_addr = (gnt0 | gnt1) ? ((rd_sel == client_idx_t'(1)) ? rd1_addr : rd0_addr)
                                       : '0;
    assign rd_data     = ram_rd_data;
    assign rd0_valid   = rd0_valid_q;
    assign rd1_valid   = rd1_valid_q;
    assign clear_busy  = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_gnt      = 1'b0;
        clear_done  = 1'b0;
        ram_wr_ena  = 1'b0;
        ram_wr_addr = wr_addr;
        ram_wr_data = wr_data;
        case (state_q)
            ST_IDLE: begin
                // A client write coinciding with clear_start lands before the clear begins.
                wr_gnt     = wr_req;
                ram_wr_ena = wr_req;
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                ram_wr_ena  = 1'b1;
                ram_wr_addr = cnt_q;
                ram_wr_data = CLEAR_VALUE;
                if (cnt_q == LAST_ROW) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + A'(1);
                end
            end
            ST_DONE: begin
                clear_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd0_valid_q <= gnt0;
            rd1_valid_q <= gnt1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_vram_scheduler : scoreboard bench for vram_scheduler with a        |
// | behavioural read-first RAM. Rev 1.0                                   |
// +-----------------------------------------------------------------------+
module tb_vram_scheduler;

    localparam int           W     = 8;
    localparam int           L     = 32;
    localparam int           A     = 5;
    localparam logic [W-1:0] CLR_V = 8'hE1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd0_req = 1'b0, rd1_req = 1'b0, wr_req = 1'b0, clear_start = 1'b0;
    logic [A-1:0] rd0_addr = '0, rd1_addr = '0, wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic         rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, wr_gnt;
    logic         clear_busy, clear_done, ram_wr_ena;
    logic [W-1:0] rd_data, ram_rd_data, ram_wr_data;
    logic [A-1:0] ram_rd_addr, ram_wr_addr;

    logic [W-1:0] mem   [L];
    logic [W-1:0] model [L];
    logic [W:0]   sbq   [$];
    logic [W:0]   exp_e;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int clr_wr_cnt = 0;

    vram_scheduler #(.W(W), .L(L), .CLEAR_VALUE(CLR_V)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt), .rd0_valid(rd0_valid),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_valid(rd1_valid),
        .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_ena(ram_wr_ena), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
    );

    always #5 clk = ~clk;

    // Registered-read, read-first block RAM.
    always @(posedge clk) begin
        ram_rd_data <= mem[ram_rd_addr];
        if (ram_wr_ena) mem[ram_wr_addr] <= ram_wr_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever read data is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd0_valid || rd1_valid) begin
                chk("rd_both_valid", 32'(rd0_valid & rd1_valid), 0);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got valid with empty scoreboard at %0t", $time);
                end else begin
                    exp_e = sbq.pop_front();
                    chk("rd_client", 32'(rd1_valid), 32'(exp_e[W]));
                    chk("rd_data", 32'(rd_data), 32'(exp_e[W-1:0]));
                end
            end
            if (clear_done) done_cnt++;
            if (ram_wr_ena && clear_busy) clr_wr_cnt++;
        end
    end

    // ck >= 0: clear write of row ck expected; -1: not busy; -2: DONE cycle.
    task automatic tick(input bit e0, input bit e1, input bit ew, input int ck);
        logic [A-1:0] exp_ra;
        #2;
        chk("rd0_gnt", 32'(rd0_gnt), 32'(e0));
        chk("rd1_gnt", 32'(rd1_gnt), 32'(e1));
        chk("wr_gnt", 32'(wr_gnt), 32'(ew));
        exp_ra = e1 ? rd1_addr : (e0 ? rd0_addr : '0);
        chk("ram_rd_addr", 32'(ram_rd_addr), 32'(exp_ra));
        chk("clear_busy", 32'(clear_busy), 32'(ck != -1));
        chk("clear_done", 32'(clear_done), 32'(ck == -2));
        if (ew) begin
            chk("ram_wr_ena", 32'(ram_wr_ena), 1);
            chk("ram_wr_addr", 32'(ram_wr_addr), 32'(wr_addr));
            chk("ram_wr_data", 32'(ram_wr_data), 32'(wr_data));
        end else if (ck >= 0) begin
            chk("clr_wr_ena", 32'(ram_wr_ena), 1);
            chk("clr_wr_addr", 32'(ram_wr_addr), 32'(ck));
            chk("clr_wr_data", 32'(ram_wr_data), 32'(CLR_V));
        end else begin
            chk("ram_wr_idle", 32'(ram_wr_ena), 0);
        end
        if (e0) sbq.push_back({1'b0, model[rd0_addr]});
        if (e1) sbq.push_back({1'b1, model[rd1_addr]});
        if (ew) model[wr_addr] = wr_data;
        if (ck >= 0) model[ck] = CLR_V;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit e0;
        for (int i = 0; i < L; i++) begin
            mem[i]   = 8'h40 + 8'(i);
            model[i] = 8'h40 + 8'(i);
        end
        mem[5] = 8'h3C; model[5] = 8'h3C;
        mem[7] = 8'h77; model[7] = 8'h77;

        #3;
        chk("rst_rd0_valid", 32'(rd0_valid), 0);
        chk("rst_rd1_valid", 32'(rd1_valid), 0);
        chk("rst_clear_busy", 32'(clear_busy), 0);
        chk("rst_clear_done", 32'(clear_done), 0);
        chk("rst_ram_rd_addr", 32'(ram_rd_addr), 0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read from client 0.
        rd0_req = 1'b1; rd0_addr = 5'd5;
        tick(1, 0, 0, -1);
        rd0_req = 1'b0;
        tick(0, 0, 0, -1);

        // Client 1 alone, leaving the round-robin pointer on client 0.
        rd1_req = 1'b1; rd1_addr = 5'd3;
        tick(0, 1, 0, -1);

        // Both clients contending for four cycles.
        rd0_req = 1'b1; rd0_addr = 5'd1; rd1_addr = 5'd2;
        for (int i = 0; i < 4; i++) begin
`ifdef VRAM_SCHED_RR_EN
            e0 = (i % 2 == 0);
`else
            e0 = 1'b1;
`endif
            tick(e0, !e0, 0, -1);
        end
        rd0_req = 1'b0; rd1_req = 1'b0;

        // Read-first collision, then read back the new value.
        rd1_req = 1'b1; rd1_addr = 5'd7;
        wr_req = 1'b1; wr_addr = 5'd7; wr_data = 8'hA5;
        tick(0, 1, 1, -1);
        rd1_req = 1'b0; wr_req = 1'b0;
        rd0_req = 1'b1; rd0_addr = 5'd7;
        tick(1, 0, 0, -1);
        rd0_req = 1'b0;

        // Clear started together with a client write.
        clear_start = 1'b1;
        wr_req = 1'b1; wr_addr = 5'd3; wr_data = 8'h99;
        tick(0, 0, 1, -1);
        clear_start = 1'b0;
        for (int k = 0; k < L; k++) begin
            rd0_req = (k == 4); rd0_addr = 5'd31;
            clear_start = (k == 15);
            tick(k == 4, 0, 0, k);
        end
        rd0_req = 1'b0; clear_start = 1'b0;
        tick(0, 0, 0, -2);
        wr_req = 1'b0;
        tick(0, 0, 0, -1);

        for (int i = 0; i < L; i++) begin
            rd0_req = 1'b1; rd0_addr = 5'(i);
            tick(1, 0, 0, -1);
        end
        rd0_req = 1'b0;

        // Fill with a pattern, then abort a clear by reset at counter 10.
        for (int i = 0; i < L; i++) begin
            wr_req = 1'b1; wr_addr = 5'(i); wr_data = 8'(i * 7 + 8'h21);
            tick(0, 0, 1, -1);
        end
        wr_req = 1'b0;
        clear_start = 1'b1;
        tick(0, 0, 0, -1);
        clear_start = 1'b0;
        for (int k = 0; k < 10; k++) tick(0, 0, 0, k);
        rst_n = 1'b0;
        #1;
        chk("abort_clear_busy", 32'(clear_busy), 0);
        chk("abort_clear_done", 32'(clear_done), 0);
        chk("abort_ram_wr_ena", 32'(ram_wr_ena), 0);
        chk("abort_rd0_valid", 32'(rd0_valid), 0);
        chk("abort_rd1_valid", 32'(rd1_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick(0, 0, 0, -1);
        for (int i = 0; i < L; i++) begin
            rd1_req = 1'b1; rd1_addr = 5'(i);
            tick(0, 1, 0, -1);
        end
        rd1_req = 1'b0;
        tick(0, 0, 0, -1);
        tick(0, 0, 0, -1);

        chk("scoreboard_empty", 32'(sbq.size()), 0);
        chk("clear_done_pulses", 32'(done_cnt), 1);
        chk("clear_write_count", 32'(clr_wr_cnt), 42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
